// File: rtl/beat_step_sequencer.sv
// Beat-driven step sequencer: plays a small programmable note pattern, one step per
// tempo beat, and sends note-on/note-off events to the synth voice over valid/ready.
module beat_step_sequencer #(
  parameter int NUM_STEPS = 16,
  parameter int NOTE_W    = 7,
  parameter int GATE_W    = 16,
  parameter int SW        = $clog2(NUM_STEPS)
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              run,
  input  logic              beat_tick,
  input  logic [SW-1:0]     seq_len,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              pat_we,
  input  logic [SW-1:0]     pat_addr,
  input  logic [NOTE_W:0]   pat_wdata,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              ev_note_on,
  output logic [NOTE_W-1:0] ev_note,
  output logic              gate,
  output logic [SW-1:0]     cur_step,
  output logic [7:0]        overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_ON  = 2'd1,
    GATE     = 2'd2,
    SEND_OFF = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [NOTE_W:0]   pat_q [NUM_STEPS];
  logic [SW-1:0]     step_q, step_d;
  logic              pending_q, pending_d;
  logic [GATE_W-1:0] cnt_q, cnt_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [7:0]        overrun_q, overrun_d;

  logic [NOTE_W:0]   fetch_entry;
  logic              fetch;
  logic              entry_en;
  logic [SW-1:0]     step_next;
  logic [GATE_W-1:0] gate_load;

  assign fetch_entry = pat_q[step_q];
  assign entry_en    = fetch_entry[NOTE_W];
  assign fetch       = (state_q == IDLE) && run && (beat_tick || pending_q);
  assign step_next   = (step_q >= seq_len) ? '0 : step_q + SW'(1);
  assign gate_load   = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;

  // A same-cycle write and fetch of one address returns the old entry, since the
  // fetch reads the array before this edge commits the write.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        pat_q[i] <= '0;
      end
    end else if (pat_we) begin
      pat_q[pat_addr] <= pat_wdata;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (fetch && entry_en) state_d = SEND_ON;
      SEND_ON:  if (ev_ready) state_d = GATE;
      GATE:     if ((cnt_q <= GATE_W'(1)) || beat_tick || !run) state_d = SEND_OFF;
      SEND_OFF: if (ev_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ev_valid   = 1'b0;
    ev_note_on = 1'b0;
    ev_note    = '0;
    gate       = 1'b0;
    case (state_q)
      SEND_ON: begin
        ev_valid   = 1'b1;
        ev_note_on = 1'b1;
        ev_note    = note_q;
      end
      GATE: gate = 1'b1;
      SEND_OFF: begin
        ev_valid = 1'b1;
        ev_note  = note_q;
      end
      default: ;
    endcase
  end

  // Beats arriving outside IDLE are remembered once; any further beat before the
  // remembered one is consumed counts as an overrun.
  always_comb begin
    step_d    = step_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    note_d    = note_q;
    overrun_d = overrun_q;

    if ((state_q != IDLE) && beat_tick) begin
      if (pending_q) begin
        if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (!run) begin
          step_d = '0;
        end else if (fetch) begin
          pending_d = 1'b0;
          if (entry_en) begin
            note_d = fetch_entry[NOTE_W-1:0];
          end else begin
            step_d = step_next;
          end
        end
      end
      SEND_ON: if (ev_ready) cnt_d = gate_load;
      GATE:    if (cnt_q != '0) cnt_d = cnt_q - GATE_W'(1);
      SEND_OFF: if (ev_ready) step_d = step_next;
      default: ;
    endcase

    if (!run) pending_d = 1'b0;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      step_q    <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      note_q    <= '0;
      overrun_q <= '0;
    end else begin
      step_q    <= step_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      note_q    <= note_d;
      overrun_q <= overrun_d;
    end
  end

  assign cur_step    = step_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_beat_step_sequencer.sv
// Directed bench for beat_step_sequencer: hand-computed event sequences, latencies,
// gate lengths and overrun counts for each scenario.
module tb_beat_step_sequencer;

  localparam int NUM_STEPS = 16;
  localparam int NOTE_W    = 7;
  localparam int GATE_W    = 16;
  localparam int SW        = 4;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic              run = 1'b0;
  logic              beat_tick = 1'b0;
  logic [SW-1:0]     seq_len = '0;
  logic [GATE_W-1:0] gate_cycles = '0;
  logic              pat_we = 1'b0;
  logic [SW-1:0]     pat_addr = '0;
  logic [NOTE_W:0]   pat_wdata = '0;
  logic              ev_ready = 1'b0;
  logic              ev_valid;
  logic              ev_note_on;
  logic [NOTE_W-1:0] ev_note;
  logic              gate;
  logic [SW-1:0]     cur_step;
  logic [7:0]        overrun_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gateCnt = 0;
  int base = 0;
  int firstBeat = 0;
  int evQ[$];
  int evCycQ[$];
  int evGateQ[$];

  beat_step_sequencer #(
    .NUM_STEPS(NUM_STEPS),
    .NOTE_W(NOTE_W),
    .GATE_W(GATE_W)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .run(run),
    .beat_tick(beat_tick),
    .seq_len(seq_len),
    .gate_cycles(gate_cycles),
    .pat_we(pat_we),
    .pat_addr(pat_addr),
    .pat_wdata(pat_wdata),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_note_on(ev_note_on),
    .ev_note(ev_note),
    .gate(gate),
    .cur_step(cur_step),
    .overrun_cnt(overrun_cnt)
  );

  always #5 ACLK = ~ACLK;

  // Event log: code = note_on<<8 | note, edge index of the handshake, and for
  // note-off events the number of edges gate was seen high since the note-on.
  always @(posedge ACLK) begin
    cyc = cyc + 1;
    if (gate) gateCnt = gateCnt + 1;
    if (ev_valid && ev_ready) begin
      evQ.push_back((int'(ev_note_on) << 8) | int'(ev_note));
      evCycQ.push_back(cyc);
      evGateQ.push_back(ev_note_on ? 0 : gateCnt);
      if (ev_note_on) gateCnt = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic applyStimulus(input int beats, input int period);
    for (int i = 0; i < beats; i++) begin
      beat_tick = 1'b1;
      tick();
      if (i == 0) firstBeat = cyc;
      beat_tick = 1'b0;
      repeat (period - 1) tick();
    end
  endtask

  task automatic writeStep(input int addr, input logic [NOTE_W:0] data);
    pat_we    = 1'b1;
    pat_addr  = SW'(addr);
    pat_wdata = data;
    tick();
    pat_we = 1'b0;
  endtask

  task automatic resetDut();
    ARESETN   = 1'b0;
    run       = 1'b0;
    beat_tick = 1'b0;
    pat_we    = 1'b0;
    ev_ready  = 1'b0;
    repeat (2) tick();
    ARESETN = 1'b1;
    tick();
  endtask

  initial begin
    #2;
    checkOutput("reset_outputs", {ev_valid, ev_note_on, ev_note, gate, cur_step, overrun_cnt}, 32'h0);
    resetDut();

    // Basic pattern with a rest and a wrap back to step 0.
    writeStep(0, 8'hBC);
    writeStep(2, 8'hC0);
    seq_len = 4'd2; gate_cycles = 16'd4; ev_ready = 1'b1; run = 1'b1;
    base = evQ.size();
    applyStimulus(4, 20);
    checkOutput("s1_count", evQ.size() - base, 6);
    checkOutput("s1_on_latency", evCycQ[base] - firstBeat, 1);
    checkOutput("s1_ev0", evQ[base], 32'h13C);
    checkOutput("s1_ev1", evQ[base+1], 32'h03C);
    checkOutput("s1_off_delay", evCycQ[base+1] - evCycQ[base], 5);
    checkOutput("s1_gate_len0", evGateQ[base+1], 4);
    checkOutput("s1_ev2", evQ[base+2], 32'h140);
    checkOutput("s1_ev2_time", evCycQ[base+2] - evCycQ[base], 40);
    checkOutput("s1_ev3", evQ[base+3], 32'h040);
    checkOutput("s1_gate_len2", evGateQ[base+3], 4);
    checkOutput("s1_ev4_wrap", evQ[base+4], 32'h13C);
    checkOutput("s1_cur_step", cur_step, 1);

    // Backpressure on the note-on.
    resetDut();
    writeStep(0, 8'hBC);
    seq_len = 4'd2; gate_cycles = 16'd4; run = 1'b1; ev_ready = 1'b0;
    base = evQ.size();
    applyStimulus(1, 1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("s2_hold", {ev_valid, ev_note_on, ev_note, gate}, {1'b1, 1'b1, 7'h3C, 1'b0});
      tick();
    end
    ev_ready = 1'b1;
    tick();
    checkOutput("s2_after_hs", {ev_valid, gate}, 2'b01);
    checkOutput("s2_ev0", evQ[base], 32'h13C);
    repeat (8) tick();
    checkOutput("s2_ev1", evQ[base+1], 32'h03C);

    // Long gate cut short by the next beat.
    resetDut();
    writeStep(0, 8'hBC);
    writeStep(1, 8'hBE);
    writeStep(2, 8'hC0);
    seq_len = 4'd2; gate_cycles = 16'd100; ev_ready = 1'b1; run = 1'b1;
    base = evQ.size();
    applyStimulus(2, 20);
    checkOutput("s3_count", evQ.size() - base, 3);
    checkOutput("s3_ev1", evQ[base+1], 32'h03C);
    checkOutput("s3_early_off", evCycQ[base+1] - evCycQ[base], 20);
    checkOutput("s3_ev2", evQ[base+2], 32'h13E);
    checkOutput("s3_next_on", evCycQ[base+2] - evCycQ[base+1], 2);
    checkOutput("s3_overrun", overrun_cnt, 0);

    // Note-off stalled across three beats: one pends, two overrun.
    resetDut();
    writeStep(0, 8'hBC);
    writeStep(1, 8'hBE);
    writeStep(2, 8'hC0);
    seq_len = 4'd2; gate_cycles = 16'd4; ev_ready = 1'b1; run = 1'b1;
    base = evQ.size();
    applyStimulus(1, 1);
    repeat (4) tick();
    ev_ready = 1'b0;
    repeat (15) tick();
    applyStimulus(3, 20);
    checkOutput("s4_off_hold", {ev_valid, ev_note_on, ev_note}, {1'b1, 1'b0, 7'h3C});
    checkOutput("s4_overrun", overrun_cnt, 2);
    ev_ready = 1'b1;
    repeat (12) tick();
    checkOutput("s4_count", evQ.size() - base, 4);
    checkOutput("s4_ev2", evQ[base+2], 32'h13E);
    checkOutput("s4_resume", evCycQ[base+2] - evCycQ[base+1], 2);
    checkOutput("s4_ev3", evQ[base+3], 32'h03E);
    checkOutput("s4_cur_step", cur_step, 2);

    // Asynchronous reset while a note sounds.
    applyStimulus(1, 1);
    repeat (3) tick();
    checkOutput("s6_gate_before", gate, 1);
    #2;
    ARESETN = 1'b0;
    #1;
    checkOutput("s6_async_reset", {ev_valid, ev_note_on, ev_note, gate, cur_step, overrun_cnt}, 32'h0);
    tick();
    ARESETN = 1'b1;
    base = evQ.size();
    run = 1'b1; ev_ready = 1'b1;
    applyStimulus(2, 10);
    checkOutput("s6_no_events", evQ.size() - base, 0);
    checkOutput("s6_rest_steps", cur_step, 2);

    // run falls during the gate.
    resetDut();
    writeStep(0, 8'hC5);
    seq_len = 4'd2; gate_cycles = 16'd100; ev_ready = 1'b1; run = 1'b1;
    base = evQ.size();
    applyStimulus(1, 1);
    repeat (4) tick();
    checkOutput("s5_gate_on", gate, 1);
    run = 1'b0;
    tick();
    checkOutput("s5_send_off", {ev_valid, ev_note_on, ev_note, gate}, {1'b1, 1'b0, 7'h45, 1'b0});
    repeat (2) tick();
    checkOutput("s5_step_zero", cur_step, 0);
    checkOutput("s5_ev0", evQ[base], 32'h145);
    checkOutput("s5_ev1", evQ[base+1], 32'h045);
    applyStimulus(2, 10);
    checkOutput("s5_idle_count", evQ.size() - base, 2);
    checkOutput("s5_idle_outs", {ev_valid, gate}, 2'b00);

    // Zero gate length, seq_len 0, and a write colliding with the fetch.
    resetDut();
    writeStep(0, 8'hB0);
    seq_len = 4'd0; gate_cycles = 16'd0; ev_ready = 1'b1; run = 1'b1;
    base = evQ.size();
    beat_tick = 1'b1; pat_we = 1'b1; pat_addr = 4'd0; pat_wdata = 8'h00;
    tick();
    beat_tick = 1'b0; pat_we = 1'b0;
    repeat (9) tick();
    checkOutput("s7_old_data", evQ[base], 32'h130);
    checkOutput("s7_gate_len", evGateQ[base+1], 1);
    checkOutput("s7_off_delay", evCycQ[base+1] - evCycQ[base], 2);
    applyStimulus(1, 10);
    checkOutput("s7_count", evQ.size() - base, 2);
    checkOutput("s7_cur_step", cur_step, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
